alu_multicycle: RTL and testbench

- Parametrised, handshaked successor to the datapath ALU for the multicycle MIPS core.
- Issued once per instruction during the execute stage.
- Single-cycle ops: add/sub/logic/shift/set-less-than.
- Iterative ops: signed/unsigned multiply and divide, using a shift-add / restoring FSM.
- Registered result, HI/LO pair, zero/overflow/div-by-zero flags and branch offset go to the memory/write-back stages.

---
 rtl/alu_multicycle.sv | 221 ++++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Execute-stage ALU for the multicycle MIPS core: single-cycle integer ops plus
// iterative shift-add multiply and restoring divide, with a start/in_ready handshake.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             in_ready,
  input  logic [WIDTH-1:0] read_data1,
  input  logic [WIDTH-1:0] read_data2,
  input  logic [WIDTH-1:0] sign_extend,
  input  logic             alu_src,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       alu_funct,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] branch_value,
  output logic             out_valid
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX} state_e;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_SLL, OP_SRL, OP_SRA, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_NONE
  } op_e;

  state_e state_q, state_d;
  op_e    op;

  logic [WIDTH-1:0] a, b, sum, diff, sc_result;
  logic [SHW-1:0]   shamt;
  logic             sc_ovf, is_iter, is_signed_iter, is_div_op;
  logic [WIDTH-1:0] mag_a, mag_b;

  // Iterative-unit state: acc holds {hi, lo} for multiply and {rem, quot} for divide.
  logic [2*WIDTH-1:0] acc, mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]   divisor, a_orig, bv_hold, q_fix, r_fix;
  logic [SHW-1:0]     cnt;
  logic               it_div, neg_q, neg_r, dbz_r, dovf_r;
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [WIDTH-1:0]   fin_lo, fin_hi;

  assign a     = read_data1;
  assign b     = alu_src ? sign_extend : read_data2;
  assign shamt = b[SHW-1:0];
  assign sum   = a + b;
  assign diff  = a - b;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    op = OP_NONE;
    case (alu_op)
      2'b00:   op = OP_ADD;
      2'b01:   op = OP_SUB;
      default: begin
        case (alu_funct)
          6'b100000: op = OP_ADD;
          6'b100010: op = OP_SUB;
          6'b100100: op = OP_AND;
          6'b100101: op = OP_OR;
          6'b100110: op = OP_XOR;
          6'b100111: op = OP_NOR;
          6'b101010: op = OP_SLT;
          6'b101011: op = OP_SLTU;
          6'b000000: op = OP_SLL;
          6'b000010: op = OP_SRL;
          6'b000011: op = OP_SRA;
          6'b011000: op = OP_MULT;
          6'b011001: op = OP_MULTU;
          6'b011010: op = OP_DIV;
          6'b011011: op = OP_DIVU;
          default:   op = OP_NONE;
        endcase
      end
    endcase
  end

  always_comb begin
    sc_result = '0;
    sc_ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        sc_result = sum;
        sc_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_result = diff;
        sc_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  sc_result = a & b;
      OP_OR:   sc_result = a | b;
      OP_XOR:  sc_result = a ^ b;
      OP_NOR:  sc_result = ~(a | b);
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  sc_result = a << shamt;
      OP_SRL:  sc_result = a >> shamt;
      OP_SRA:  sc_result = WIDTH'($signed(a) >>> shamt);
      default: begin
        sc_result = '0;
        sc_ovf    = 1'b0;
      end
    endcase
  end

  assign is_iter        = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign is_signed_iter = (op == OP_MULT) || (op == OP_DIV);
  assign is_div_op      = (op == OP_DIV) || (op == OP_DIVU);
  assign mag_a          = (is_signed_iter && a[WIDTH-1]) ? -a : a;
  assign mag_b          = (is_signed_iter && b[WIDTH-1]) ? -b : b;

  // One multiplier bit (LSB of acc) or one quotient bit per BUSY cycle.
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, divisor} : '0);
  assign mul_next  = {mul_sum, acc[WIDTH-1:1]};
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, divisor};
  assign div_next  = div_trial[WIDTH]
                   ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                   : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign prod_fix = neg_q ? -acc : acc;
  assign q_fix    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    fin_lo = prod_fix[WIDTH-1:0];
    fin_hi = prod_fix[2*WIDTH-1:WIDTH];
    if (it_div) begin
      fin_lo = dbz_r ? '1     : q_fix;
      fin_hi = dbz_r ? a_orig : r_fix;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = (state_q == S_IDLE);
    case (state_q)
      S_IDLE:  if (start && is_iter) state_d = S_BUSY;
      S_BUSY:  if (cnt == '0) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      result       <= '0;
      result_hi    <= '0;
      zero         <= 1'b0;
      overflow     <= 1'b0;
      div_by_zero  <= 1'b0;
      branch_value <= '0;
      out_valid    <= 1'b0;
      acc          <= '0;
      divisor      <= '0;
      a_orig       <= '0;
      bv_hold      <= '0;
      cnt          <= '0;
      it_div       <= 1'b0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      dbz_r        <= 1'b0;
      dovf_r       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && is_iter) begin
            acc     <= {{WIDTH{1'b0}}, mag_a};
            divisor <= mag_b;
            a_orig  <= a;
            bv_hold <= sign_extend;
            cnt     <= SHW'(WIDTH - 1);
            it_div  <= is_div_op;
            neg_q   <= is_signed_iter && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r   <= is_signed_iter && a[WIDTH-1];
            dbz_r   <= is_div_op && (b == '0);
            dovf_r  <= (op == OP_DIV) && (a == MIN_VAL) && (b == '1);
          end else if (start) begin
            result       <= sc_result;
            result_hi    <= '0;
            zero         <= (sc_result == '0);
            overflow     <= sc_ovf;
            div_by_zero  <= 1'b0;
            branch_value <= sign_extend;
            out_valid    <= 1'b1;
          end
        end
        S_BUSY: begin
          acc <= it_div ? div_next : mul_next;
          cnt <= cnt - 1'b1;
        end
        S_FIX: begin
          result       <= fin_lo;
          result_hi    <= fin_hi;
          zero         <= (fin_lo == '0);
          overflow     <= dovf_r;
          div_by_zero  <= dbz_r;
          branch_value <= bv_hold;
          out_valid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: table of single-cycle and iterative vectors at
// WIDTH=32, plus back-to-back, mid-op reset and a WIDTH=8 instance.
module tb_alu_multicycle;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  fn;
    logic        src;
    logic [31:0] a, b, se;
    logic [31:0] res, hi;
    logic        z, ov, dz, chk_z;
    int          lat;
  } vec_t;

  localparam int NV = 23;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  int          checks = 0;
  int          errors = 0;

  logic        start32 = 1'b0, alu_src32 = 1'b0;
  logic [1:0]  alu_op32 = '0;
  logic [5:0]  alu_funct32 = '0;
  logic [31:0] read_data1 = '0, read_data2 = '0, sign_extend = '0;
  logic        in_ready32, zero32, overflow32, dbz32, out_valid32;
  logic [31:0] result32, result_hi32, branch32;

  logic        start8 = 1'b0;
  logic [1:0]  alu_op8 = '0;
  logic [5:0]  alu_funct8 = '0;
  logic [7:0]  a8 = '0, b8 = '0, se8 = '0;
  logic        in_ready8, zero8, overflow8, dbz8, out_valid8;
  logic [7:0]  result8, result_hi8, branch8;

  vec_t vecs [NV];

  always #5 clock = ~clock;

  alu_multicycle #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset), .start(start32), .in_ready(in_ready32),
    .read_data1(read_data1), .read_data2(read_data2), .sign_extend(sign_extend),
    .alu_src(alu_src32), .alu_op(alu_op32), .alu_funct(alu_funct32),
    .result(result32), .result_hi(result_hi32), .zero(zero32), .overflow(overflow32),
    .div_by_zero(dbz32), .branch_value(branch32), .out_valid(out_valid32)
  );

  alu_multicycle #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .in_ready(in_ready8),
    .read_data1(a8), .read_data2(b8), .sign_extend(se8),
    .alu_src(1'b0), .alu_op(alu_op8), .alu_funct(alu_funct8),
    .result(result8), .result_hi(result_hi8), .zero(zero8), .overflow(overflow8),
    .div_by_zero(dbz8), .branch_value(branch8), .out_valid(out_valid8)
  );

  task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic run32(input int idx, input vec_t v);
    int   n;
    logic rdy_seen;
    alu_op32    = v.op;
    alu_funct32 = v.fn;
    alu_src32   = v.src;
    read_data1  = v.a;
    read_data2  = v.b;
    sign_extend = v.se;
    start32     = 1'b1;
    @(posedge clock); #1;
    start32    = 1'b0;
    read_data1 = ~v.a;
    sign_extend = 32'hDEAD_BEEF;
    n = 0;
    rdy_seen = 1'b0;
    while (!out_valid32 && n < 100) begin
      rdy_seen = rdy_seen | in_ready32;
      start32  = (n == 5);
      @(posedge clock); #1;
      n++;
    end
    start32 = 1'b0;
    check("latency", idx, n, v.lat);
    if (v.lat > 0) check("ready_while_busy", idx, rdy_seen, 0);
    check("result", idx, result32, v.res);
    check("result_hi", idx, result_hi32, v.hi);
    check("overflow", idx, overflow32, v.ov);
    check("div_by_zero", idx, dbz32, v.dz);
    check("branch_value", idx, branch32, v.se);
    check("in_ready_done", idx, in_ready32, 1);
    if (v.chk_z) check("zero", idx, zero32, v.z);
    @(posedge clock); #1;
    check("valid_pulse", idx, out_valid32, 0);
  endtask

  task automatic run8(input int idx, input logic [5:0] fn, input logic [7:0] a, input logic [7:0] b,
                      input int exp_lat, input logic [7:0] exp_res, input logic [7:0] exp_hi);
    int n;
    alu_op8 = 2'b10;
    alu_funct8 = fn;
    a8 = a;
    b8 = b;
    se8 = 8'h5A;
    start8 = 1'b1;
    @(posedge clock); #1;
    start8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    check("w8_latency", idx, n, exp_lat);
    check("w8_result", idx, result8, exp_res);
    check("w8_result_hi", idx, result_hi8, exp_hi);
    @(posedge clock); #1;
  endtask

  initial begin
    int n;
    int seen;
    //              op     fn         src a             b             se            res           hi            z  ov dz cz lat
    vecs[0]  = '{2'b01, 6'b000000, 0, 32'd25,       32'd25,       32'd64,       32'd0,        32'd0,        1, 0, 0, 1, 0};
    vecs[1]  = '{2'b10, 6'b100000, 0, 32'h7FFFFFFF, 32'd1,        32'h1001,     32'h80000000, 32'd0,        0, 1, 0, 1, 0};
    vecs[2]  = '{2'b10, 6'b101010, 0, 32'hFFFFFFFF, 32'd1,        32'h1002,     32'd1,        32'd0,        0, 0, 0, 1, 0};
    vecs[3]  = '{2'b10, 6'b101011, 0, 32'hFFFFFFFF, 32'd1,        32'h1003,     32'd0,        32'd0,        1, 0, 0, 1, 0};
    vecs[4]  = '{2'b00, 6'b000000, 1, 32'd10,       32'd999,      32'hFFFFFFFE, 32'd8,        32'd0,        0, 0, 0, 1, 0};
    vecs[5]  = '{2'b10, 6'b100010, 0, 32'h80000000, 32'd1,        32'h1005,     32'h7FFFFFFF, 32'd0,        0, 1, 0, 1, 0};
    vecs[6]  = '{2'b10, 6'b100100, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h1006,     32'hF000F000, 32'd0,        0, 0, 0, 1, 0};
    vecs[7]  = '{2'b10, 6'b100101, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h1007,     32'hFFF0FFF0, 32'd0,        0, 0, 0, 1, 0};
    vecs[8]  = '{2'b10, 6'b100110, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h1008,     32'h0FF00FF0, 32'd0,        0, 0, 0, 1, 0};
    vecs[9]  = '{2'b10, 6'b100111, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h1009,     32'h000F000F, 32'd0,        0, 0, 0, 1, 0};
    vecs[10] = '{2'b10, 6'b000000, 0, 32'd1,        32'h24,       32'h100A,     32'h10,       32'd0,        0, 0, 0, 1, 0};
    vecs[11] = '{2'b10, 6'b000010, 0, 32'h80000000, 32'h1F,       32'h100B,     32'd1,        32'd0,        0, 0, 0, 1, 0};
    vecs[12] = '{2'b10, 6'b000011, 0, 32'h80000000, 32'd4,        32'h100C,     32'hF8000000, 32'd0,        0, 0, 0, 1, 0};
    vecs[13] = '{2'b10, 6'b111111, 0, 32'd5,        32'd5,        32'h100D,     32'd0,        32'd0,        0, 0, 0, 0, 0};
    vecs[14] = '{2'b10, 6'b011000, 0, 32'hFFFFFFFD, 32'd7,        32'h100E,     32'hFFFFFFEB, 32'hFFFFFFFF, 0, 0, 0, 1, 33};
    vecs[15] = '{2'b10, 6'b011010, 0, 32'hFFFFFFF9, 32'd2,        32'h100F,     32'hFFFFFFFD, 32'hFFFFFFFF, 0, 0, 0, 1, 33};
    vecs[16] = '{2'b10, 6'b011010, 0, 32'd5,        32'd0,        32'h1010,     32'hFFFFFFFF, 32'd5,        0, 0, 1, 1, 33};
    vecs[17] = '{2'b10, 6'b011010, 0, 32'h80000000, 32'hFFFFFFFF, 32'h1011,     32'h80000000, 32'd0,        0, 1, 0, 1, 33};
    vecs[18] = '{2'b10, 6'b011001, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1012,     32'd1,        32'hFFFFFFFE, 0, 0, 0, 1, 33};
    vecs[19] = '{2'b10, 6'b011011, 0, 32'hFFFFFFFF, 32'd2,        32'h1013,     32'h7FFFFFFF, 32'd1,        0, 0, 0, 1, 33};
    vecs[20] = '{2'b10, 6'b011010, 0, 32'd7,        32'hFFFFFFFE, 32'h1014,     32'hFFFFFFFD, 32'd1,        0, 0, 0, 1, 33};
    vecs[21] = '{2'b10, 6'b011000, 0, 32'h80000000, 32'h80000000, 32'h1015,     32'd0,        32'h40000000, 1, 0, 0, 1, 33};
    vecs[22] = '{2'b10, 6'b011011, 0, 32'd100,      32'd7,        32'h1016,     32'd14,       32'd2,        0, 0, 0, 1, 33};

    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready", 0, in_ready32, 1);
    check("rst_out_valid", 0, out_valid32, 0);
    check("rst_result", 0, result32, 0);
    check("rst_branch", 0, branch32, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < NV; i++) run32(i, vecs[i]);

    // Back-to-back single-cycle issue: start held high across two edges.
    alu_op32 = 2'b00; alu_src32 = 1'b0; read_data1 = 32'd3; read_data2 = 32'd4; sign_extend = 32'h77;
    start32 = 1'b1;
    @(posedge clock); #1;
    check("b2b_valid0", 100, out_valid32, 1);
    check("b2b_result0", 100, result32, 32'd7);
    check("b2b_ready0", 100, in_ready32, 1);
    alu_op32 = 2'b01; read_data1 = 32'd3; read_data2 = 32'd4;
    @(posedge clock); #1;
    start32 = 1'b0;
    check("b2b_valid1", 101, out_valid32, 1);
    check("b2b_result1", 101, result32, 32'hFFFFFFFF);
    @(posedge clock); #1;

    // Reset during BUSY of a divu discards the op.
    alu_op32 = 2'b10; alu_funct32 = 6'b011011; read_data1 = 32'd1000; read_data2 = 32'd3;
    start32 = 1'b1;
    @(posedge clock); #1;
    start32 = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("mid_rst_in_ready", 200, in_ready32, 1);
    check("mid_rst_result", 200, result32, 0);
    check("mid_rst_hi", 200, result_hi32, 0);
    check("mid_rst_flags", 200, {zero32, overflow32, dbz32}, 0);
    check("mid_rst_branch", 200, branch32, 0);
    check("mid_rst_valid", 200, out_valid32, 0);
    seen = 0;
    for (n = 0; n < 40; n++) begin
      @(posedge clock); #1;
      if (out_valid32) seen++;
    end
    check("mid_rst_no_valid", 200, seen, 0);
    run32(201, vecs[1]);

    run8(300, 6'b011001, 8'hFF, 8'hFF, 9, 8'h01, 8'hFE);
    run8(301, 6'b000011, 8'h80, 8'h03, 0, 8'hF0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
